// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus bit-serial shifts,
// with a valid/ready handshake on both request and result sides.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             cf,
   output logic             vf,
   output logic             sf,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_PASS = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_SLTU = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       sel_q, sel_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zf_q, zf_d, cf_q, cf_d, vf_q, vf_d, sf_q, sf_d;

   logic [WIDTH:0]   add_s, sub_s;
   logic [WIDTH-1:0] alu_res_s, shifted_s;
   logic             alu_cf_s, alu_vf_s, alu_shift_s;
   logic [SHW-1:0]   shamt_s;

   // {zero, sign} flags of a finished result
   function automatic logic [1:0] zs_flags(input logic [WIDTH-1:0] r);
      return {(r == {WIDTH{1'b0}}), r[MSB]};
   endfunction

   assign shamt_s = b[SHW-1:0];

   // Single-cycle ALU evaluated on the live request inputs
   always_comb begin
      add_s       = {1'b0, a} + {1'b0, b};
      sub_s       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res_s   = {WIDTH{1'b0}};
      alu_cf_s    = 1'b0;
      alu_vf_s    = 1'b0;
      alu_shift_s = 1'b0;
      case (sel)
         OP_ADD: begin
            alu_res_s = add_s[MSB:0];
            alu_cf_s  = add_s[WIDTH];
            alu_vf_s  = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res_s = sub_s[MSB:0];
            alu_cf_s  = sub_s[WIDTH];
            alu_vf_s  = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
         end
         OP_PASS: alu_res_s = b;
         OP_OR:   alu_res_s = a | b;
         OP_AND:  alu_res_s = a & b;
         OP_XOR:  alu_res_s = a ^ b;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SRL, OP_SLL, OP_SRA: begin
            alu_res_s   = a;
            alu_shift_s = 1'b1;
         end
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One-bit step of the captured shift operand; SRA keeps the original sign bit
   always_comb begin
      case (sel_q)
         OP_SRL:  shifted_s = {1'b0, sh_q[MSB:1]};
         OP_SLL:  shifted_s = {sh_q[MSB-1:0], 1'b0};
         OP_SRA:  shifted_s = {sh_q[MSB], sh_q[MSB:1]};
         default: shifted_s = sh_q;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zf_d    = zf_q;
      cf_d    = cf_q;
      vf_d    = vf_q;
      sf_d    = sf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sel_d = sel;
               sh_d  = a;
               cnt_d = shamt_s;
               if (alu_shift_s && (shamt_s != {SHW{1'b0}})) begin
                  state_d = SHIFT;
               end else begin
                  state_d      = DONE;
                  res_d        = alu_res_s;
                  cf_d         = alu_cf_s;
                  vf_d         = alu_vf_s;
                  {zf_d, sf_d} = zs_flags(alu_res_s);
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sh_d  = shifted_s;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d      = DONE;
               res_d        = shifted_s;
               cf_d         = 1'b0;
               vf_d         = 1'b0;
               {zf_d, sf_d} = zs_flags(shifted_s);
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 4'b0000;
         sh_q    <= {WIDTH{1'b0}};
         cnt_q   <= {SHW{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         zf_q    <= 1'b0;
         cf_q    <= 1'b0;
         vf_q    <= 1'b0;
         sf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zf_q    <= zf_d;
         cf_q    <= cf_d;
         vf_q    <= vf_d;
         sf_q    <= sf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign zf        = zf_q;
   assign cf        = cf_q;
   assign vf        = vf_q;
   assign sf        = sf_q;

endmodule
